// File: rtl/alarm_ctrl_if.sv
// Set-alarm handshake between a host (master) and alarm_ctrl (slave).
// The host offers a new alarm time; the controller signals readiness and rejects out-of-range requests.
interface alarm_ctrl_if;
    logic       set_valid;
    logic [4:0] set_hr;
    logic [5:0] set_min;
    logic       set_ready;
    logic       set_err;

    modport master (
        output set_valid, set_hr, set_min,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_hr, set_min,
        output set_ready, set_err
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller beside the time-of-day counter: stores the alarm time, rings on a match,
// and handles snooze, stop and ring timeout.
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alarm_ctrl_if.slave   set_if,
    input  logic          tick,
    input  logic [4:0]    hr,
    input  logic [5:0]    min,
    input  logic [5:0]    sec,
    input  logic          arm,
    input  logic          snooze,
    input  logic          stop,
    output logic          alarm_on,
    output logic [1:0]    state,
    output logic [4:0]    alm_hr,
    output logic [5:0]    alm_min,
    output logic [1:0]    snooze_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2,
        S_SNOOZE  = 2'd3
    } state_t;

    // The 2-bit snooze count saturates at 3, so the limit is clamped to what it can represent.
    localparam int               MAX_SN_I    = (MAX_SNOOZE > 3) ? 3 : MAX_SNOOZE;
    localparam logic [1:0]       MAX_SN      = MAX_SN_I[1:0];
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_snz, w_snz_nxt;
    logic [4:0]       r_alm_hr;
    logic [5:0]       r_alm_min;
    logic             r_set_err;

    logic w_set_ready;
    logic w_set_fire;
    logic w_set_ok;
    logic w_match;

    assign w_set_ready = (r_state == S_IDLE) || (r_state == S_ARMED);
    assign w_set_fire  = set_if.set_valid && w_set_ready;
    assign w_set_ok    = (set_if.set_hr <= 5'd23) && (set_if.set_min <= 6'd59);
    // Compares against the stored alarm, so a same-edge set transfer cannot affect this match.
    assign w_match     = tick && (hr == r_alm_hr) && (min == r_alm_min) && (sec == 6'd0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_snz_nxt   = r_snz;

        if (!arm) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_snz_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_ARMED;
                S_ARMED: begin
                    if (w_match) begin
                        w_state_nxt = S_RINGING;
                        w_cnt_nxt   = '0;
                        w_snz_nxt   = '0;
                    end
                end
                S_RINGING: begin
                    if (stop) begin
                        w_state_nxt = S_ARMED;
                        w_cnt_nxt   = '0;
                    end else if (snooze) begin
                        w_cnt_nxt = '0;
                        if (r_snz < MAX_SN) begin
                            w_state_nxt = S_SNOOZE;
                            w_snz_nxt   = r_snz + 2'd1;
                        end else begin
                            w_state_nxt = S_ARMED;
                        end
                    end else if (tick) begin
                        if (r_cnt == RING_LAST) begin
                            w_state_nxt = S_ARMED;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_SNOOZE: begin
                    if (stop) begin
                        w_state_nxt = S_ARMED;
                        w_cnt_nxt   = '0;
                    end else if (tick) begin
                        if (r_cnt == SNOOZE_LAST) begin
                            w_state_nxt = S_RINGING;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_snz   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_snz   <= w_snz_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alm_hr  <= '0;
            r_alm_min <= '0;
            r_set_err <= 1'b0;
        end else begin
            r_set_err <= w_set_fire && !w_set_ok;
            if (w_set_fire && w_set_ok) begin
                r_alm_hr  <= set_if.set_hr;
                r_alm_min <= set_if.set_min;
            end
        end
    end

    assign set_if.set_ready = w_set_ready;
    assign set_if.set_err   = r_set_err;
    assign alarm_on         = (r_state == S_RINGING);
    assign state            = r_state;
    assign alm_hr           = r_alm_hr;
    assign alm_min          = r_alm_min;
    assign snooze_cnt       = r_snz;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: the driver pushes the reference model's expected outputs per edge,
// a monitor pops and compares them on the following falling edge.
module tb_alarm_ctrl;

    localparam int RING_SEC   = 4;
    localparam int SNOOZE_SEC = 5;
    localparam int MAX_SNOOZE = 3;
    localparam int DAY        = 86400;

    logic       clk, rst_n, tick, arm, snooze, stop;
    logic [4:0] hr;
    logic [5:0] min, sec;
    logic       alarm_on;
    logic [1:0] state;
    logic [4:0] alm_hr;
    logic [5:0] alm_min;
    logic [1:0] snooze_cnt;

    alarm_ctrl_if sif ();

    alarm_ctrl #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .MAX_SNOOZE(MAX_SNOOZE),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_if    (sif.slave),
        .tick      (tick),
        .hr        (hr),
        .min       (min),
        .sec       (sec),
        .arm       (arm),
        .snooze    (snooze),
        .stop      (stop),
        .alarm_on  (alarm_on),
        .state     (state),
        .alm_hr    (alm_hr),
        .alm_min   (alm_min),
        .snooze_cnt(snooze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes 0 idle, 1 armed, 2 ringing, 3 snoozing; timers count down remaining ticks.
    typedef struct {
        int state;
        int alarm_on;
        int ready;
        int err;
        int ahr;
        int amin;
        int snz;
    } exp_t;

    exp_t sb_q[$];
    int   tod;
    int   m_mode, m_ahr, m_amin, m_ring_left, m_snz_left, m_snoozes, m_err;

    task automatic model_reset();
        m_mode = 0; m_ahr = 0; m_amin = 0; m_snoozes = 0; m_err = 0;
        m_ring_left = 0; m_snz_left = 0;
    endtask

    task automatic model_step(input int now);
        int   old_alarm;
        exp_t e;
        old_alarm = m_ahr * 3600 + m_amin * 60;
        m_err = 0;
        if (sif.set_valid && m_mode <= 1) begin
            if (int'(sif.set_hr) <= 23 && int'(sif.set_min) <= 59) begin
                m_ahr  = int'(sif.set_hr);
                m_amin = int'(sif.set_min);
            end else begin
                m_err = 1;
            end
        end
        if (!arm) begin
            m_mode = 0;
            m_snoozes = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (tick && now == old_alarm) begin
                m_mode = 2; m_ring_left = RING_SEC; m_snoozes = 0;
            end
        end else if (m_mode == 2) begin
            if (stop) m_mode = 1;
            else if (snooze) begin
                if (m_snoozes < MAX_SNOOZE) begin
                    m_mode = 3; m_snz_left = SNOOZE_SEC; m_snoozes++;
                end else m_mode = 1;
            end else if (tick) begin
                m_ring_left--;
                if (m_ring_left == 0) m_mode = 1;
            end
        end else begin
            if (stop) m_mode = 1;
            else if (tick) begin
                m_snz_left--;
                if (m_snz_left == 0) begin
                    m_mode = 2; m_ring_left = RING_SEC;
                end
            end
        end
        e.state = m_mode;   e.alarm_on = (m_mode == 2); e.ready = (m_mode <= 1);
        e.err   = m_err;    e.ahr = m_ahr; e.amin = m_amin; e.snz = m_snoozes;
        sb_q.push_back(e);
    endtask

    // One clock edge: drive inputs, record the expectation, and return at falling edge + 1.
    task automatic step(input bit t, input bit stp, input bit snz, input bit sv, input int shr, input int smin);
        tick = t; stop = stp; snooze = snz;
        hr  = 5'(tod / 3600);
        min = 6'((tod / 60) % 60);
        sec = 6'(tod % 60);
        sif.set_valid = sv;
        sif.set_hr    = 5'(shr);
        sif.set_min   = 6'(smin);
        model_step(tod);
        @(negedge clk);
        #1;
        if (t) tod = (tod + 1) % DAY;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},    int'(state),         0);
        check({tag, "_alarm_on"}, int'(alarm_on),      0);
        check({tag, "_ready"},    int'(sif.set_ready), 1);
        check({tag, "_err"},      int'(sif.set_err),   0);
        check({tag, "_alm_hr"},   int'(alm_hr),        0);
        check({tag, "_alm_min"},  int'(alm_min),       0);
        check({tag, "_snz"},      int'(snooze_cnt),    0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_state",    int'(state),         e.state);
                check("sb_alarm_on", int'(alarm_on),      e.alarm_on);
                check("sb_ready",    int'(sif.set_ready), e.ready);
                check("sb_err",      int'(sif.set_err),   e.err);
                check("sb_alm_hr",   int'(alm_hr),        e.ahr);
                check("sb_alm_min",  int'(alm_min),       e.amin);
                check("sb_snz",      int'(snooze_cnt),    e.snz);
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; arm = 1'b0; tick = 1'b0; stop = 1'b0; snooze = 1'b0;
        hr = '0; min = '0; sec = '0;
        sif.set_valid = 1'b0; sif.set_hr = '0; sif.set_min = '0;
        tod = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;

        // Arm and program 07:30, then reject 24:10 while armed.
        arm = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 7, 30);
        check("armed", int'(state), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 24, 10);
        check("bad_set_err", int'(sif.set_err), 1);
        check("bad_set_hr", int'(alm_hr), 7);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("err_one_cycle", int'(sif.set_err), 0);

        // Match at 07:30:00, ring RING_SEC ticks with a tickless cycle inside, no retrigger at 07:31:00.
        tod = 7 * 3600 + 29 * 60 + 59;
        ticks(1);
        check("pre_match", int'(state), 1);
        ticks(1);
        check("ring_start", int'(alarm_on), 1);
        ticks(RING_SEC - 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("ring_hold", int'(state), 2);
        ticks(1);
        check("ring_timeout", int'(state), 1);
        ticks(60);
        check("no_retrigger", int'(state), 1);

        // Snooze three times (held snooze on first tick), fourth snooze acts as stop.
        tod = 7 * 3600 + 29 * 59 + 0;
        tod = 7 * 3600 + 29 * 60 + 59;
        ticks(2);
        for (int k = 1; k <= MAX_SNOOZE; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
            check("snooze_state", int'(state), 3);
            check("snooze_count", int'(snooze_cnt), k);
            step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
            ticks(SNOOZE_SEC - 1);
            check("re_ring", int'(state), 2);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        check("snooze_as_stop", int'(state), 1);

        // stop with snooze in the same cycle.
        tod = 7 * 3600 + 29 * 60 + 59;
        ticks(2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        ticks(SNOOZE_SEC);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        check("stop_wins", int'(state), 1);
        check("stop_snz_kept", int'(snooze_cnt), 1);

        // Drop arm during snooze.
        tod = 7 * 3600 + 29 * 60 + 59;
        ticks(2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        ticks(1);
        arm = 1'b0;
        ticks(1);
        check("disarm_idle", int'(state), 0);
        check("disarm_alm", int'(alm_min), 30);
        arm = 1'b1;
        ticks(1);

        // Asynchronous reset in the middle of ringing.
        tod = 7 * 3600 + 29 * 60 + 59;
        ticks(3);
        check("pre_reset_ring", int'(state), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic; occasionally jump the clock to just before the alarm time.
        for (int i = 0; i < 3000; i++) begin
            bit sv;
            if ($urandom_range(0, 99) < 2) arm = ~arm;
            if ($urandom_range(0, 99) < 3)
                tod = (m_ahr * 3600 + m_amin * 60 - int'($urandom_range(0, 3)) + DAY) % DAY;
            sv = ($urandom_range(0, 99) < 4);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 6), sv,
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
        end

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
